// File: rtl/usb_resume_pkg.sv
// rtl/usb_resume_pkg.sv - shared types and default timing constants for usb_resume_gen
package usb_resume_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSP    = 2'd1,
        ST_DRIVE_K = 2'd2
    } state_t;

    localparam int unsigned SUSPEND_CYCLES_DEF   = 144000;
    localparam int unsigned WAKE_IDLE_CYCLES_DEF = 240000;
    localparam int unsigned RESUME_CYCLES_DEF    = 96000;
    localparam int unsigned IDLE_CNT_W           = 18;

endpackage

// File: rtl/usb_rx_sync.sv
// rtl/usb_rx_sync.sv - two-flop synchronizer for the D+/D- receive pair
module usb_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic p_in,
    input  logic n_in,
    output logic p_out,
    output logic n_out
);

    logic [1:0] p_stage;
    logic [1:0] n_stage;

    // Resets to SE0 so no phantom J is counted while the pipe fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_stage <= 2'b00;
            n_stage <= 2'b00;
        end else begin
            p_stage <= {p_stage[0], p_in};
            n_stage <= {n_stage[0], n_in};
        end
    end

    assign p_out = p_stage[1];
    assign n_out = n_stage[1];

endmodule

// File: rtl/usb_resume_gen.sv
// rtl/usb_resume_gen.sv - USB suspend detect and remote-wakeup K driver; optional USB_RESUME_SYNC_EN rx synchronizer
module usb_resume_gen
    import usb_resume_pkg::*;
#(
    parameter int unsigned SUSPEND_CYCLES   = SUSPEND_CYCLES_DEF,
    parameter int unsigned WAKE_IDLE_CYCLES = WAKE_IDLE_CYCLES_DEF,
    parameter int unsigned RESUME_CYCLES    = RESUME_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic usb_p_rx,
    input  logic usb_n_rx,
    input  logic wake_en,
    input  logic wake_req,
    output logic suspended,
    output logic resume_busy,
    output logic wake_done,
    output logic usb_p_tx,
    output logic usb_n_tx,
    output logic usb_tx_en
);

    localparam logic [IDLE_CNT_W-1:0] SUSP_N   = IDLE_CNT_W'(SUSPEND_CYCLES);
    localparam logic [IDLE_CNT_W-1:0] WAKE_N   = IDLE_CNT_W'(WAKE_IDLE_CYCLES);
    localparam logic [IDLE_CNT_W-1:0] RES_LAST = IDLE_CNT_W'(RESUME_CYCLES - 1);

    logic line_j;

`ifdef USB_RESUME_SYNC_EN
    logic p_sync;
    logic n_sync;

    usb_rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .p_in  (usb_p_rx),
        .n_in  (usb_n_rx),
        .p_out (p_sync),
        .n_out (n_sync)
    );

    assign line_j = p_sync & ~n_sync;
`else
    assign line_j = usb_p_rx & ~usb_n_rx;
`endif

    state_t                state, state_next;
    logic                  pending, pending_next;
    logic [IDLE_CNT_W-1:0] idle_cnt, idle_next;
    logic [IDLE_CNT_W-1:0] res_cnt, res_next;
    logic                  done_next;

    always_comb begin
        state_next   = state;
        pending_next = pending;
        idle_next    = idle_cnt;
        res_next     = res_cnt;
        done_next    = 1'b0;

        if (state == ST_DRIVE_K) begin
            // Our own K shows up on rx here, so the line is not observed.
            idle_next    = '0;
            pending_next = 1'b0;
            if (res_cnt == RES_LAST) begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
                res_next   = '0;
            end else begin
                res_next = res_cnt + 1'b1;
            end
        end else begin
            if (!line_j)
                idle_next = '0;
            else if (idle_cnt >= WAKE_N)
                idle_next = WAKE_N;
            else
                idle_next = idle_cnt + 1'b1;

            if (!wake_en)
                pending_next = 1'b0;

            case (state)
                ST_IDLE: begin
                    pending_next = 1'b0;
                    if (idle_next >= SUSP_N)
                        state_next = ST_SUSP;
                end
                ST_SUSP: begin
                    if (!line_j) begin
                        state_next   = ST_IDLE;
                        pending_next = 1'b0;
                    end else if (pending && wake_en && idle_next == WAKE_N) begin
                        state_next   = ST_DRIVE_K;
                        pending_next = 1'b0;
                        res_next     = '0;
                    end else if (wake_req && wake_en) begin
                        pending_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            idle_cnt    <= '0;
            res_cnt     <= '0;
            suspended   <= 1'b0;
            resume_busy <= 1'b0;
            wake_done   <= 1'b0;
            usb_tx_en   <= 1'b0;
            usb_p_tx    <= 1'b1;
            usb_n_tx    <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            idle_cnt    <= idle_next;
            res_cnt     <= res_next;
            suspended   <= (state_next == ST_SUSP);
            resume_busy <= pending_next || (state_next == ST_DRIVE_K);
            wake_done   <= done_next;
            usb_tx_en   <= (state_next == ST_DRIVE_K);
            usb_p_tx    <= (state_next != ST_DRIVE_K);
            usb_n_tx    <= (state_next == ST_DRIVE_K);
        end
    end

endmodule

// File: doc/usb_resume_gen.md
# usb_resume_gen

Device-side USB remote-wakeup signaller: the transmit-direction counterpart of the bus-reset detector. It watches the full-speed line for bus idle (J), flags suspend, and when firmware requests a wakeup it drives resume K onto D+/D- for a fixed time and then releases the bus. It sits beside the USB PHY pads, sharing the raw `usb_p_rx`/`usb_n_rx` inputs, and contends for the transmit pads with the serial-interface-engine (SIE) transmitter.

## Interface
Parameters:
- `SUSPEND_CYCLES`, 144000 — consecutive J cycles before `suspended` asserts (3 ms at 48 MHz).
- `WAKE_IDLE_CYCLES`, 240000 — minimum consecutive J cycles before K may be driven (5 ms).
- `RESUME_CYCLES`, 96000 — K drive duration in cycles (2 ms).

Ports:
- `clk` in 1 — sole clock.
- `reset` in 1 — synchronous, active-high.
- `usb_p_rx` in 1 — D+ receive.
- `usb_n_rx` in 1 — D- receive.
- `wake_en` in 1 — host-enabled DEVICE_REMOTE_WAKEUP feature.
- `wake_req` in 1 — single-cycle wakeup request pulse from firmware.
- `suspended` out 1 — bus is in suspend.
- `resume_busy` out 1 — request pending or K being driven.
- `wake_done` out 1 — one-cycle pulse when K drive ends.
- `usb_p_tx` out 1 — D+ drive value.
- `usb_n_tx` out 1 — D- drive value.
- `usb_tx_en` out 1 — pad output enable. When high, this block owns the pads.

## Operation
- Line state is J when `usb_p_rx` is 1 and `usb_n_rx` is 0. Every other combination counts as activity.
- `idle_cnt` is 18 bits. It increments on each J sample, saturates at `WAKE_IDLE_CYCLES`, and clears to 0 on any non-J sample.
- States:
  - IDLE → SUSP when `idle_cnt` reaches `SUSPEND_CYCLES`.
  - SUSP → IDLE on any non-J sample (host activity or resume). This clears any pending request.
  - SUSP + `pending` + `idle_cnt`==`WAKE_IDLE_CYCLES` → DRIVE_K.
  - DRIVE_K → IDLE after exactly `RESUME_CYCLES` cycles. This pulses `wake_done` and clears `idle_cnt`.
- `pending` sets on `wake_req` only while in SUSP with `wake_en`=1. In any other state, `wake_req` is ignored. `wake_en` falling while pending and not yet in DRIVE_K cancels the request. Once in DRIVE_K, the drive always completes.
- In DRIVE_K the rx inputs are ignored, because the device's own K appears on rx.
- `resume_busy` = `pending` OR state==DRIVE_K.
- The port is not hot-pluggable: an SE0 seen in SUSP behaves as ordinary activity and returns the block to IDLE.

## Timing
- Reset values: `suspended`=0, `resume_busy`=0, `wake_done`=0, `usb_tx_en`=0, `usb_p_tx`=1, `usb_n_tx`=0. After reset, state is IDLE, `idle_cnt`=0 and `pending`=0.
- All outputs are registered.
- `suspended` rises in the cycle after the `SUSPEND_CYCLES`th consecutive J sample, and falls in the cycle after the first non-J sample.
- `usb_tx_en`=1, `usb_p_tx`=0 and `usb_n_tx`=1 hold for exactly `RESUME_CYCLES` cycles.
- `usb_tx_en` falls together with the single-cycle `wake_done` pulse. `usb_p_tx`/`usb_n_tx` return to 1/0.
- If `pending` sets after idle has already saturated, DRIVE_K begins the cycle after `pending` is set.
- When `wake_req` and a non-J sample arrive in the same cycle, the exit to IDLE wins and `pending` stays 0.
- `reset` asserted during DRIVE_K drops `usb_tx_en` on the next edge.

## Configuration
- `USB_RESUME_SYNC_EN` defined: `usb_p_rx`/`usb_n_rx` pass through a two-flop synchronizer before line-state decode. All rx-referenced timing gains 2 cycles of latency.
- Undefined: the raw inputs are decoded directly, which is correct when they are already synchronous to `clk`.

## Structure
- Package `usb_resume_pkg` holds:
  - the state enum (IDLE, SUSP, DRIVE_K);
  - the default cycle constants;
  - `IDLE_CNT_W`=18.
- Sub-module `usb_rx_sync` is the two-flop synchronizer for the D+/D- pair. It is instantiated only under `USB_RESUME_SYNC_EN`.
- All other logic is in one module.

## Test plan
Bench parameters: `SUSPEND_CYCLES`=30, `WAKE_IDLE_CYCLES`=50, `RESUME_CYCLES`=20, with the macro undefined.
- Hold J for 29 cycles then K for 1 cycle → `suspended` never rises. Hold J for 30 cycles → `suspended`=1 in the following cycle.
- J for 35 cycles, then `wake_req` with `wake_en`=1:
  - `usb_tx_en` rises in the cycle after the 50th J sample;
  - K is driven for 20 cycles;
  - `wake_done` pulses once;
  - `suspended`=0.
- `wake_req` while `suspended`=0, or with `wake_en`=0 → no drive, and `resume_busy` stays 0.
- Pending request, then a non-J sample at idle count 40 → `suspended`=0, `pending` cleared, no K driven.
- `reset` pulsed 5 cycles into DRIVE_K → `usb_tx_en`=0 on the next edge, and all outputs return to their reset values.
- Host toggles D+/D- to K while the block is driving K → `usb_tx_en` still lasts exactly 20 cycles.
